// File: rtl/pwm_led_dimmer.sv
// pwm_led_dimmer: multi-channel PWM LED brightness controller.
//
// One shared prescaler and period counter drive CHANNELS per-channel lanes.
// Each lane has a pending duty register, written at any time. The active
// duty is loaded from the pending register only at period boundaries, so
// duty updates never glitch. A lane can instead run a triangle "breathe"
// ramp on its active duty.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   enable        1 = run PWM; 0 = hold counters at 0, LEDs off
//   duty_wr_en    write strobe for a pending duty register
//   duty_wr_ch    target channel; values >= CHANNELS are ignored
//   duty_wr_data  new duty 0..2^RES_BITS; larger values clamp to 2^RES_BITS
//   breathe_en    per-channel mode: 0 = fixed duty, 1 = breathe ramp
//   led           registered PWM outputs
//   period_start  1-cycle pulse on the first cycle of each new period

// One channel: pending/active duty, breathe direction and the output compare.
module pwm_led_dimmer_lane #(
    parameter int RES_BITS     = 8,
    parameter int BREATHE_STEP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                boundary,
    input  logic                breathe,
    input  logic                wr,
    input  logic [RES_BITS:0]   wr_data,
    input  logic [RES_BITS-1:0] cnt,
    output logic                led
);
    localparam int DW = RES_BITS + 1;
    localparam logic [DW-1:0] FULL = {1'b1, {RES_BITS{1'b0}}};
    localparam logic [DW-1:0] STEP = DW'(BREATHE_STEP);

    logic [DW-1:0] pending, active, active_d;
    logic          dir_up, dir_d;
    logic [DW:0]   up_sum;
    logic          hit_top, hit_bot;

    // One extra bit so FULL + STEP cannot wrap before the saturation test.
    assign up_sum  = {1'b0, active} + {1'b0, STEP};
    assign hit_top = up_sum >= {1'b0, FULL};
    assign hit_bot = active <= STEP;

    always_comb begin
        active_d = active;
        dir_d    = dir_up;
        if (!enable) begin
            // While idle, fixed lanes track pending so re-enable starts fresh.
            if (!breathe) active_d = pending;
        end else if (boundary) begin
            if (!breathe) begin
                active_d = pending;
            end else if (dir_up) begin
                if (hit_top) begin
                    active_d = FULL;
                    dir_d    = 1'b0;
                end else begin
                    active_d = up_sum[DW-1:0];
                end
            end else begin
                if (hit_bot) begin
                    active_d = '0;
                    dir_d    = 1'b1;
                end else begin
                    active_d = active - STEP;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            active  <= '0;
            dir_up  <= 1'b1;
            led     <= 1'b0;
        end else begin
            if (wr) pending <= wr_data;
            active <= active_d;
            dir_up <= dir_d;
            led    <= enable && ({1'b0, cnt} < active);
        end
    end
endmodule

module pwm_led_dimmer #(
    parameter int   CHANNELS     = 3,
    parameter int   RES_BITS     = 8,
    parameter int   PRESCALE     = 1,
    parameter int   BREATHE_STEP = 1,
    localparam int  CW           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                duty_wr_en,
    input  logic [CW-1:0]       duty_wr_ch,
    input  logic [RES_BITS:0]   duty_wr_data,
    input  logic [CHANNELS-1:0] breathe_en,
    output logic [CHANNELS-1:0] led,
    output logic                period_start
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = RES_BITS + 1;
    localparam logic [DW-1:0] FULL = {1'b1, {RES_BITS{1'b0}}};

    logic [PW-1:0]       pre;
    logic [RES_BITS-1:0] cnt;
    logic                tick, boundary;
    logic [DW-1:0]       wr_clamped;

    assign tick       = enable && (pre == PW'(PRESCALE - 1));
    assign boundary   = tick && (cnt == '1);
    assign wr_clamped = (duty_wr_data > FULL) ? FULL : duty_wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre          <= '0;
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (!enable) begin
                pre <= '0;
                cnt <= '0;
            end else begin
                pre <= tick ? '0 : pre + PW'(1);
                if (tick) cnt <= cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        pwm_led_dimmer_lane #(
            .RES_BITS    (RES_BITS),
            .BREATHE_STEP(BREATHE_STEP)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable),
            .boundary(boundary),
            .breathe (breathe_en[i]),
            // Out-of-range channel numbers never match any lane index.
            .wr      (duty_wr_en && (duty_wr_ch == CW'(i))),
            .wr_data (wr_clamped),
            .cnt     (cnt),
            .led     (led[i])
        );
    end
endmodule

// File: tb/tb_pwm_led_dimmer.sv
// Directed bench for pwm_led_dimmer (3 channels, 4-bit resolution, prescale 2,
// breathe step 4): period = 32 clk cycles, led high = 2*duty cycles.
module tb_pwm_led_dimmer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       duty_wr_en = 1'b0;
    logic [1:0] duty_wr_ch = '0;
    logic [4:0] duty_wr_data = '0;
    logic [2:0] breathe_en = '0;
    logic [2:0] led;
    logic       period_start;

    int checks = 0;
    int errors = 0;

    pwm_led_dimmer #(
        .CHANNELS(3), .RES_BITS(4), .PRESCALE(2), .BREATHE_STEP(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .duty_wr_en(duty_wr_en), .duty_wr_ch(duty_wr_ch), .duty_wr_data(duty_wr_data),
        .breathe_en(breathe_en), .led(led), .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [4:0] d);
        duty_wr_en = 1'b1; duty_wr_ch = ch; duty_wr_data = d;
        step();
        duty_wr_en = 1'b0;
    endtask

    // Step until the cycle where period_start is high (at least one step).
    task automatic sync(input string tag);
        int found = 0;
        for (int k = 0; k < 80 && found == 0; k++) begin
            step();
            if (period_start) found = 1;
        end
        chk(tag, found, 1);
    endtask

    // Called on a period's first cycle (period_start high, or enable just set);
    // counts led highs over the next 32 cycles, optionally issuing one write
    // sampled at edge number wr_at.
    task automatic run_period(input int wr_at, input logic [1:0] wch, input logic [4:0] wdat,
                              output int h0, output int h1, output int h2,
                              output int ps, output logic [2:0] first);
        h0 = 0; h1 = 0; h2 = 0; ps = 0; first = '0;
        for (int j = 0; j < 32; j++) begin
            if (j == wr_at) begin
                duty_wr_en = 1'b1; duty_wr_ch = wch; duty_wr_data = wdat;
            end
            step();
            duty_wr_en = 1'b0;
            if (j == 0) first = led;
            h0 += int'(led[0]); h1 += int'(led[1]); h2 += int'(led[2]);
            ps += int'(period_start);
        end
    endtask

    task automatic per(input string tag, input int wr_at, input logic [1:0] wch,
                       input logic [4:0] wdat, input int e0, input int e1, input int e2);
        int h0, h1, h2, ps;
        logic [2:0] first;
        run_period(wr_at, wch, wdat, h0, h1, h2, ps, first);
        chk({tag, "_hi0"}, h0, e0);
        chk({tag, "_hi1"}, h1, e1);
        chk({tag, "_hi2"}, h2, e2);
        chk({tag, "_ps"}, ps, 1);
    endtask

    initial begin
        int h0, h1, h2, ps;
        logic [2:0] first;

        // Reset state
        step(); step();
        chk("rst_led", int'(led), 0);
        chk("rst_ps", int'(period_start), 0);
        rst = 1'b0;
        step();

        // 1: program while disabled, then enable
        wr(2'd0, 5'd4); wr(2'd1, 5'd8); wr(2'd2, 5'd12);
        step(); step();
        chk("t1_idle_led", int'(led), 0);
        chk("t1_idle_ps", int'(period_start), 0);
        enable = 1'b1;
        run_period(-1, 2'd0, 5'd0, h0, h1, h2, ps, first);
        chk("t1_rise", int'(first), 7);
        chk("t1_hi0", h0, 8);
        chk("t1_hi1", h1, 16);
        chk("t1_hi2", h2, 24);
        chk("t1_ps", ps, 1);
        per("t1b", -1, 2'd0, 5'd0, 8, 16, 24);

        // 2: duty limits, 31 clamps to 16
        wr(2'd0, 5'd0); wr(2'd1, 5'd16); wr(2'd2, 5'd31);
        sync("t2_sync");
        per("t2", -1, 2'd0, 5'd0, 0, 32, 32);

        // 3: mid-period write, boundary-coincident write, out-of-range channel
        per("t3a", 5, 2'd1, 5'd8, 0, 32, 32);
        per("t3b", -1, 2'd0, 5'd0, 0, 16, 32);
        per("t3c", 5, 2'd1, 5'd2, 0, 16, 32);
        per("t3d", -1, 2'd0, 5'd0, 0, 4, 32);
        per("t3e", 31, 2'd1, 5'd6, 0, 4, 32);
        per("t3f", -1, 2'd0, 5'd0, 0, 4, 32);
        per("t3g", -1, 2'd0, 5'd0, 0, 12, 32);
        per("t3h", 3, 2'd3, 5'd20, 0, 12, 32);
        per("t3i", -1, 2'd0, 5'd0, 0, 12, 32);

        // 4: breathe on ch0 from active 0: duty 4,8,12,16,12,8,4,0,4
        breathe_en = 3'b001;
        per("t4_0", -1, 2'd0, 5'd0, 0, 12, 32);
        per("t4_1", -1, 2'd0, 5'd0, 8, 12, 32);
        per("t4_2", -1, 2'd0, 5'd0, 16, 12, 32);
        per("t4_3", -1, 2'd0, 5'd0, 24, 12, 32);
        per("t4_4", -1, 2'd0, 5'd0, 32, 12, 32);
        per("t4_5", -1, 2'd0, 5'd0, 24, 12, 32);
        per("t4_6", -1, 2'd0, 5'd0, 16, 12, 32);
        per("t4_7", -1, 2'd0, 5'd0, 8, 12, 32);
        per("t4_8", -1, 2'd0, 5'd0, 0, 12, 32);
        per("t4_9", -1, 2'd0, 5'd0, 8, 12, 32);
        // Back to fixed: ramp already advanced to 8, pending reloads next boundary
        breathe_en = 3'b000;
        per("t4_fx0", 2, 2'd0, 5'd10, 16, 12, 32);
        per("t4_fx1", -1, 2'd0, 5'd0, 20, 12, 32);

        // 5: asynchronous reset mid-period
        step(); step(); step();
        chk("t5_pre", int'(led), 7);
        rst = 1'b1;
        #1;
        chk("t5_async", int'(led), 0);
        step(); step();
        chk("t5_hold_led", int'(led), 0);
        chk("t5_hold_ps", int'(period_start), 0);
        rst = 1'b0;
        sync("t5_sync");
        per("t5", -1, 2'd0, 5'd0, 0, 0, 0);

        // 6: drop and restore enable mid-period
        wr(2'd0, 5'd4); wr(2'd1, 5'd8); wr(2'd2, 5'd12);
        sync("t6_sync");
        per("t6a", -1, 2'd0, 5'd0, 8, 16, 24);
        step(); step(); step(); step();
        chk("t6_mid", int'(led), 7);
        enable = 1'b0;
        step();
        chk("t6_off", int'(led), 0);
        step(); step(); step();
        chk("t6_off_led", int'(led), 0);
        chk("t6_off_ps", int'(period_start), 0);
        wr(2'd1, 5'd2);
        step(); step();
        enable = 1'b1;
        run_period(-1, 2'd0, 5'd0, h0, h1, h2, ps, first);
        chk("t6_rise", int'(first), 7);
        chk("t6_hi0", h0, 8);
        chk("t6_hi1", h1, 4);
        chk("t6_hi2", h2, 24);
        chk("t6_ps", ps, 1);
        per("t6b", -1, 2'd0, 5'd0, 8, 4, 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
